origin_shift_pipe: RTL

ORIGIN_SHIFT_PIPE -- requirements
Module: origin_shift_pipe

---
 rtl/render_pkg.sv | 11 +
 rtl/origin_shift_axis.sv | 43 ++++
 rtl/origin_shift_pipe.sv | 102 ++++++++++
 3 files changed

// File: rtl/render_pkg.sv
// Shared render types: the vec3 coordinate struct and the vertex index width.
package render_pkg;
  localparam int VEC3_W    = 16;
  localparam int VTX_IDX_W = 4;

  typedef struct packed {
    logic signed [VEC3_W-1:0] x;
    logic signed [VEC3_W-1:0] y;
    logic signed [VEC3_W-1:0] z;
  } vec3_t;
endpackage

// File: rtl/origin_shift_axis.sv
// One coordinate axis: registered in-origin subtract, then registered saturate/wrap.
// ORIGIN_SHIFT_SAT_EN selects clamping; otherwise overflow wraps modulo 2^DATA_W.
module origin_shift_axis #(
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ld1_i,
  input  logic                     ld2_i,
  input  logic signed [DATA_W-1:0] in_i,
  input  logic signed [DATA_W-1:0] org_i,
  output logic                     ovf_o,
  output logic signed [DATA_W-1:0] res_o
);
  localparam logic signed [DATA_W-1:0] MAX_V = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};

  logic signed [DATA_W:0]   diff_d, diff_q;
  logic signed [DATA_W-1:0] res_d, res_q;

  assign diff_d = {in_i[DATA_W-1], in_i} - {org_i[DATA_W-1], org_i};

  // Top two bits disagree exactly when the difference does not fit in DATA_W.
  assign ovf_o = diff_q[DATA_W] ^ diff_q[DATA_W-1];

`ifdef ORIGIN_SHIFT_SAT_EN
  assign res_d = !ovf_o ? diff_q[DATA_W-1:0] : (diff_q[DATA_W] ? MIN_V : MAX_V);
`else
  assign res_d = diff_q[DATA_W-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_q <= '0;
      res_q  <= '0;
    end else begin
      if (ld1_i) diff_q <= diff_d;
      if (ld2_i) res_q  <= res_d;
    end
  end

  assign res_o = res_q;
endmodule

// File: rtl/origin_shift_pipe.sv
// Two-stage elastic vertex pipe subtracting a per-primitive origin from each vertex.
// Define ORIGIN_SHIFT_SAT_EN to clamp overflowing results instead of wrapping.
module origin_shift_pipe
  import render_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int VTX_PER_PRIM = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     org_load,
  input  logic signed [DATA_W-1:0] org_x,
  input  logic signed [DATA_W-1:0] org_y,
  input  logic signed [DATA_W-1:0] org_z,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_x,
  input  logic signed [DATA_W-1:0] in_y,
  input  logic signed [DATA_W-1:0] in_z,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_x,
  output logic signed [DATA_W-1:0] out_y,
  output logic signed [DATA_W-1:0] out_z,
  output logic [VTX_IDX_W-1:0]     out_idx,
  output logic                     out_last,
  output logic                     ovf_sticky,
  input  logic                     ovf_clr
);
  localparam logic [VTX_IDX_W-1:0] LAST_IDX = VTX_IDX_W'(VTX_PER_PRIM - 1);

  logic [2:0][DATA_W-1:0]   org_in, vtx_in, org_use, res;
  logic [2:0][DATA_W-1:0]   pend_q, act_q;
  logic [2:0]               ovf;
  logic [2:1]               vld_pipe_q, vld_pipe_d;
  logic [VTX_IDX_W-1:0]     cnt_q, cnt_d, idx1_q, idx2_q;
  logic                     rdy_en_q, ovf_q;
  logic                     adv2, ld2, in_fire, prim_start;

  assign org_in = {org_z, org_y, org_x};
  assign vtx_in = {in_z, in_y, in_x};

  assign adv2       = !vld_pipe_q[2] || out_ready;
  assign ld2        = vld_pipe_q[1] && adv2;
  // rdy_en_q keeps in_ready low through reset and for the edge it is released on.
  assign in_ready   = rdy_en_q && (!vld_pipe_q[1] || adv2);
  assign in_fire    = in_valid && in_ready;
  assign prim_start = in_fire && (cnt_q == '0);

  // Index-0 vertex latches a new active origin, taking a same-cycle load directly.
  assign org_use = !prim_start ? act_q : (org_load ? org_in : pend_q);
  assign cnt_d   = (cnt_q == LAST_IDX) ? '0 : cnt_q + 1'b1;

  assign vld_pipe_d[1] = in_fire || (vld_pipe_q[1] && !ld2);
  assign vld_pipe_d[2] = ld2 || (vld_pipe_q[2] && !out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      rdy_en_q   <= 1'b0;
      cnt_q      <= '0;
      idx1_q     <= '0;
      idx2_q     <= '0;
      pend_q     <= '0;
      act_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      rdy_en_q   <= 1'b1;
      vld_pipe_q <= vld_pipe_d;
      if (org_load)   pend_q <= org_in;
      if (prim_start) act_q  <= org_use;
      if (in_fire) begin
        cnt_q  <= cnt_d;
        idx1_q <= cnt_q;
      end
      if (ld2) idx2_q <= idx1_q;
      if (ld2 && |ovf) ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
  end

  for (genvar a = 0; a < 3; a++) begin : g_axis
    origin_shift_axis #(.DATA_W(DATA_W)) u_axis (
      .clk   (clk),
      .rst_n (rst_n),
      .ld1_i (in_fire),
      .ld2_i (ld2),
      .in_i  (vtx_in[a]),
      .org_i (org_use[a]),
      .ovf_o (ovf[a]),
      .res_o (res[a])
    );
  end

  assign out_valid  = vld_pipe_q[2];
  assign out_x      = res[0];
  assign out_y      = res[1];
  assign out_z      = res[2];
  assign out_idx    = idx2_q;
  assign out_last   = (idx2_q == LAST_IDX);
  assign ovf_sticky = ovf_q;
endmodule
